// File: rtl/adaptor2x2_debug_scan_pkg.sv
// Shared types and constants for the debug-slave scan master.
package adaptor2x2_debug_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI
   } scan_state_e;

   localparam int DR_WIDTH_DEFAULT = 38;
   localparam int IR_WIDTH_DEFAULT = 2;

   // Virtual IR encodings understood by the Nios II debug slave
   localparam logic [1:0] IR_OCIMEM   = 2'd0;
   localparam logic [1:0] IR_OCIMEM_B = 2'd1;
   localparam logic [1:0] IR_BREAK    = 2'd2;
   localparam logic [1:0] IR_TRACE    = 2'd3;

   // Virtual-state flags for a state, packed as {uir, cdr, sdr, udr, rti}.
   // IDLE shares the RTI encoding: the slave sees run-test-idle between scans.
   function automatic logic [4:0] state_flags(input scan_state_e s);
      logic [4:0] f;
      case (s)
         ST_UIR:  f = 5'b10000;
         ST_CDR:  f = 5'b01000;
         ST_SDR:  f = 5'b00100;
         ST_UDR:  f = 5'b00010;
         default: f = 5'b00001;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/adaptor2x2_nios2_gen2_00_cpu_debug_scan_tckgen.sv
// TCK divider: one period is 2*TCK_HALF clk, low phase first.
// fall_stb marks the clk edge that starts a low phase, rise_stb the edge
// where tck goes high. Held at phase 0 with tck low while disabled.
module adaptor2x2_nios2_gen2_00_cpu_debug_scan_tckgen #(
   parameter int TCK_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tck,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CW = (2 * TCK_HALF > 2) ? $clog2(2 * TCK_HALF) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_tck;

   assign fall_stb = en && (r_cnt == '0);
   assign rise_stb = en && (r_cnt == CW'(TCK_HALF));
   assign tck      = r_tck;

   // Phase counter and registered tck
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == CW'(2 * TCK_HALF - 1)) ? '0 : r_cnt + CW'(1);
         if (fall_stb)      r_tck <= 1'b0;
         else if (rise_stb) r_tck <= 1'b1;
      end
   end

endmodule

// File: rtl/adaptor2x2_nios2_gen2_00_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one request
// becomes UIR, CDR, SDR x DR_WIDTH, UDR, RTI x RTI_TCKS, each a whole
// number of tck periods, and returns the captured DR word plus ir_out.
module adaptor2x2_nios2_gen2_00_cpu_debug_scan_master
   import adaptor2x2_debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
   parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
   parameter int TCK_HALF = 2,
   parameter int RTI_TCKS = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [IR_WIDTH-1:0] req_ir,
   input  logic [DR_WIDTH-1:0] req_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int PMAX = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
   localparam int PW   = $clog2(PMAX + 1);

   scan_state_e         r_state;
   logic                r_first;     // accepted, first low phase not yet begun
   logic [PW-1:0]       r_per;       // tck periods elapsed in current state
   logic [DR_WIDTH-1:0] r_shreg;
   logic                r_tdi;
   logic [4:0]          r_flags;     // {uir, cdr, sdr, udr, rti}
   logic [IR_WIDTH-1:0] r_ir_in;
   logic                r_rsp_valid;
   logic [DR_WIDTH-1:0] r_rsp_dr;
   logic [IR_WIDTH-1:0] r_rsp_ir;

   logic                w_tck;
   logic                w_fall;
   logic                w_rise;
   logic                w_accept;
   logic [PW-1:0]       w_len;
   logic                w_last;
   scan_state_e         w_adv;
   scan_state_e         w_cur;

   adaptor2x2_nios2_gen2_00_cpu_debug_scan_tckgen #(
      .TCK_HALF (TCK_HALF)
   ) u_tckgen (
      .clk      (clk),
      .reset    (reset),
      .en       (r_state != ST_IDLE),
      .tck      (w_tck),
      .fall_stb (w_fall),
      .rise_stb (w_rise)
   );

   assign req_ready  = (r_state == ST_IDLE) && !r_rsp_valid;
   assign w_accept   = req_valid && req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_dr     = r_rsp_dr;
   assign rsp_ir_out = r_rsp_ir;
   assign vji_tck    = w_tck;
   assign vji_tdi    = r_tdi;
   assign vji_ir_in  = r_ir_in;
   assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = r_flags;

   // State length (in periods, minus one) and successor state
   always_comb begin
      w_len = '0;
      w_adv = ST_IDLE;
      case (r_state)
         ST_UIR: w_adv = ST_CDR;
         ST_CDR: w_adv = ST_SDR;
         ST_SDR: begin
            w_len = PW'(DR_WIDTH - 1);
            w_adv = ST_UDR;
         end
         ST_UDR: w_adv = ST_RTI;
         ST_RTI: begin
            w_len = PW'(RTI_TCKS - 1);
            w_adv = ST_IDLE;
         end
         default: ;
      endcase
   end

   assign w_last = (r_per == w_len);
   // State of the period that begins at this fall strobe
   assign w_cur  = (r_first || !w_last) ? r_state : w_adv;

   // Scan FSM, shift register and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_first     <= 1'b0;
         r_per       <= '0;
         r_shreg     <= '0;
         r_tdi       <= 1'b0;
         r_flags     <= 5'b00001;
         r_ir_in     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_dr    <= '0;
         r_rsp_ir    <= '0;
      end else begin
         if (w_accept) begin
            r_state <= ST_UIR;
            r_first <= 1'b1;
            r_per   <= '0;
            r_ir_in <= req_ir;
            r_shreg <= req_dr;
         end else if (w_fall) begin
            // Flags and tdi move only here, a half-period before tck rises
            r_first <= 1'b0;
            r_state <= w_cur;
            r_flags <= state_flags(w_cur);
            r_tdi   <= (w_cur == ST_SDR) ? r_shreg[0] : 1'b0;
            r_per   <= (r_first || w_last) ? '0 : r_per + PW'(1);
            if (w_cur == ST_IDLE) begin
               r_rsp_valid <= 1'b1;
               r_rsp_dr    <= r_shreg;
            end
         end

         if (w_rise) begin
            if (r_state == ST_UIR) r_rsp_ir <= vji_ir_out;
            if (r_state == ST_SDR) r_shreg  <= {vji_tdo, r_shreg[DR_WIDTH-1:1]};
         end

         if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      end
   end

endmodule
